// File: rtl/instr_mem_harness_pkg.sv
// Shared types and constants for the instruction-memory harness.
//   harness_state_t : LOAD -> RELEASE -> RUN -> HALTED, left only by reset
//   RESET_VECTOR    : byte address of program word 0
//   HALT_ADDR       : fetch address that signals end of program
package instr_mem_harness_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    HALTED  = 2'd3
  } harness_state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [31:0] HALT_ADDR    = 32'h00000000;

endpackage

// File: rtl/instr_ram_array.sv
// Program storage for the harness: DEPTH x 32 words.
// Ports:
//   clk      in   write clock
//   we_i     in   write enable
//   waddr_i  in   write word index
//   wdata_i  in   write data
//   raddr_i  in   read word index (asynchronous read)
//   rdata_o  out  read data
// No reset: contents survive harness reset by design.
module instr_ram_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_mem_harness.sv
// Instruction-side responder for a Harvard MIPS CPU under test.
// Loads a program over a valid/ready port with the CPU held in reset,
// releases the CPU, serves fetches combinationally, and latches
// register_v0 when the CPU halts (fetch of address 0 while inactive)
// or when the run exceeds MAX_CYCLES.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   load_valid/ready/data/last program load handshake
//   cpu_reset, cpu_clk_enable  CPU control
//   instr_address/readdata     fetch port (readdata is combinational)
//   cpu_active, register_v0    CPU status inputs
//   halted, timeout, fault     sticky run status
//   result_v0                  register_v0 captured at halt
//   word_count                 number of program words loaded
module instr_mem_harness
  import instr_mem_harness_pkg::*;
#(
  parameter int          DEPTH      = 1024,
  parameter logic [31:0] BASE_ADDR  = RESET_VECTOR,
  parameter int          MAX_CYCLES = 10000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [31:0]              load_data,
  input  logic                     load_last,
  output logic                     cpu_reset,
  output logic                     cpu_clk_enable,
  input  logic [31:0]              instr_address,
  output logic [31:0]              instr_readdata,
  input  logic                     cpu_active,
  input  logic [31:0]              register_v0,
  output logic                     halted,
  output logic                     timeout,
  output logic                     fault,
  output logic [31:0]              result_v0,
  output logic [$clog2(DEPTH):0]   word_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(MAX_CYCLES + 1);

  harness_state_t state_q, state_d;
  logic [CW-1:0]  wc_q, wc_d;
  logic [TW-1:0]  cyc_q, cyc_d;
  logic           halted_q, halted_d;
  logic           timeout_q, timeout_d;
  logic           fault_q, fault_d;
  logic [31:0]    result_q, result_d;

  // Fetch decode
  logic [31:0]    offset;
  logic [29:0]    idx;
  logic           aligned, in_range, hit;
  logic           halt_req, fetch_bad;
  logic [31:0]    ram_rdata;
  logic           ram_we;

  assign offset   = instr_address - BASE_ADDR;  // wraps for addresses below base
  assign idx      = offset[31:2];
  assign aligned  = (offset[1:0] == 2'b00);
  // Full-width compare so addresses far past DEPTH never alias onto low words.
  assign in_range = (idx < {{(30-CW){1'b0}}, wc_q});
  assign hit      = aligned && in_range;

  assign halt_req  = (instr_address == HALT_ADDR) && !cpu_active;
  // The halt address is expected traffic, never a fault.
  assign fetch_bad = (instr_address != HALT_ADDR) && !hit;

  instr_ram_array #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wc_q[AW-1:0]),
    .wdata_i (load_data),
    .raddr_i (idx[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  assign instr_readdata = hit ? ram_rdata : 32'h0000_0000;

  // Control outputs are pure decodes of the state register.
  assign load_ready     = (state_q == LOAD);
  assign cpu_reset      = (state_q == LOAD) || (state_q == RELEASE);
  assign cpu_clk_enable = (state_q != HALTED);

  assign halted     = halted_q;
  assign timeout    = timeout_q;
  assign fault      = fault_q;
  assign result_v0  = result_q;
  assign word_count = wc_q;

  always_comb begin
    state_d   = state_q;
    wc_d      = wc_q;
    cyc_d     = cyc_q;
    halted_d  = halted_q;
    timeout_d = timeout_q;
    fault_d   = fault_q;
    result_d  = result_q;
    ram_we    = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (load_valid) begin
          ram_we = 1'b1;
          wc_d   = wc_q + 1'b1;
          // Filling the last slot ends the load even without load_last.
          if (load_last || (wc_q == CW'(DEPTH - 1))) state_d = RELEASE;
        end
      end
      RELEASE: state_d = RUN;  // one extra reset cycle after the last write
      RUN: begin
        cyc_d = cyc_q + 1'b1;
        if (fetch_bad) fault_d = 1'b1;
        // Halt takes priority over a coincident timeout.
        if (halt_req) begin
          result_d = register_v0;
          halted_d = 1'b1;
          state_d  = HALTED;
        end else if (cyc_q == TW'(MAX_CYCLES - 1)) begin
          result_d  = register_v0;
          halted_d  = 1'b1;
          timeout_d = 1'b1;
          state_d   = HALTED;
        end
      end
      HALTED: ;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= LOAD;
      wc_q      <= '0;
      cyc_q     <= '0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
      fault_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      wc_q      <= wc_d;
      cyc_q     <= cyc_d;
      halted_q  <= halted_d;
      timeout_q <= timeout_d;
      fault_q   <= fault_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_harness.sv
module tb_instr_mem_harness;

  localparam int          DEPTH = 4;
  localparam int          MAXC  = 16;
  localparam logic [31:0] BASE  = 32'hBFC00000;

  logic        clk = 1'b0, reset = 1'b0;
  logic        load_valid = 1'b0, load_last = 1'b0, cpu_active = 1'b1;
  logic [31:0] load_data = '0, instr_address = BASE, register_v0 = '0;
  logic        load_ready, cpu_reset, cpu_clk_enable, halted, timeout, fault;
  logic [31:0] instr_readdata, result_v0;
  logic [2:0]  word_count;

  instr_mem_harness #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .cpu_reset(cpu_reset), .cpu_clk_enable(cpu_clk_enable),
    .instr_address(instr_address), .instr_readdata(instr_readdata),
    .cpu_active(cpu_active), .register_v0(register_v0),
    .halted(halted), .timeout(timeout), .fault(fault),
    .result_v0(result_v0), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: phase 0=loading 1=releasing 2=running 3=finished
  int          m_ph, m_wc, m_runs;
  bit          m_halt, m_to, m_flt;
  logic [31:0] m_res;
  logic [31:0] m_mem [DEPTH];

  function automatic logic [31:0] m_fetch(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (off % 4 == 0 && off / 4 < m_wc) return m_mem[off / 4];
    return 32'h0;
  endfunction

  task automatic model_edge();
    logic [31:0] off;
    if (reset) begin
      m_ph = 0; m_wc = 0; m_runs = 0; m_halt = 0; m_to = 0; m_flt = 0; m_res = 0;
      return;
    end
    case (m_ph)
      0: if (load_valid) begin
        m_mem[m_wc] = load_data;
        m_wc++;
        if (load_last || m_wc == DEPTH) m_ph = 1;
      end
      1: m_ph = 2;
      2: begin
        m_runs++;
        off = instr_address - BASE;
        if (instr_address != 0 && (off % 4 != 0 || off / 4 >= m_wc)) m_flt = 1;
        if (instr_address == 0 && !cpu_active) begin
          m_res = register_v0; m_halt = 1; m_ph = 3;
        end else if (m_runs == MAXC) begin
          m_res = register_v0; m_halt = 1; m_to = 1; m_ph = 3;
        end
      end
      default: ;
    endcase
  endtask

  // One clock edge: check the fetch port, advance the model, check registered outputs.
  task automatic tick(input bit chk_rd = 1'b1);
    #1;
    if (chk_rd) chk("rdata", instr_readdata, m_fetch(instr_address));
    model_edge();
    @(posedge clk); #1;
    chk("load_ready", load_ready, m_ph == 0);
    chk("cpu_reset", cpu_reset, m_ph < 2);
    chk("clk_en", cpu_clk_enable, m_ph != 3);
    chk("halted", halted, m_halt);
    chk("timeout", timeout, m_to);
    chk("fault", fault, m_flt);
    chk("result_v0", result_v0, m_res);
    chk("word_count", word_count, m_wc);
  endtask

  task automatic do_reset(input bit chk_rd = 1'b1);
    reset = 1'b1;
    tick(chk_rd);
    reset = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] d, input bit last);
    load_valid = 1'b1; load_data = d; load_last = last;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1, 2:    return BASE + 4 * $urandom_range(0, DEPTH + 1);
      3:       return BASE + $urandom_range(0, 23);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (m_mem[i]) m_mem[i] = '0;
    m_ph = 0; m_wc = 0; m_runs = 0; m_halt = 0; m_to = 0; m_flt = 0; m_res = 0;

    // Reset state (DUT state unknown beforehand, so skip the fetch check)
    do_reset(1'b0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_ready", load_ready, 1);

    // 1: three-word program, reset release timing, fetch of word 1
    load_word(32'h80020000, 0);
    load_word(32'h00000008, 0);
    load_word(32'h24000000, 1);
    chk("t1_wc", word_count, 3);
    chk("t1_rst_hold", cpu_reset, 1);
    tick();
    chk("t1_rst_fall", cpu_reset, 0);
    instr_address = BASE + 4; #1;
    chk("t1_fetch", instr_readdata, 32'h00000008);

    // 2: a few in-range fetches, then halt
    repeat (3) begin instr_address = BASE + 4 * $urandom_range(0, 2); tick(); end
    instr_address = 0; cpu_active = 0; register_v0 = 32'hFFFFFFFF;
    tick();
    chk("t2_halted", halted, 1);
    chk("t2_result", result_v0, 32'hFFFFFFFF);
    chk("t2_clk_en", cpu_clk_enable, 0);
    chk("t2_timeout", timeout, 0);
    register_v0 = 32'h12345678;
    repeat (2) tick();
    cpu_active = 1; instr_address = BASE;

    // 3: misaligned and out-of-range fetches fault
    do_reset();
    load_word(32'h11111111, 1);
    tick();
    instr_address = BASE + 6; #1;
    chk("t3_mis_rd", instr_readdata, 0);
    tick();
    chk("t3_mis_fault", fault, 1);
    instr_address = BASE + 32'h10; #1;
    chk("t3_oor_rd", instr_readdata, 0);
    tick();
    chk("t3_oor_fault", fault, 1);
    do_reset();
    load_word(32'h22222222, 1);
    tick();
    instr_address = 0; cpu_active = 1;
    repeat (3) tick();
    chk("t3_zero_nofault", fault, 0);
    instr_address = BASE;

    // 4: timeout on 16th RUN edge; halt on that edge wins
    do_reset();
    load_word(32'h33333333, 0);
    load_word(32'h44444444, 1);
    tick();
    register_v0 = 32'hA5A5A5A5;
    repeat (MAXC - 1) tick();
    chk("t4_not_yet", halted, 0);
    tick();
    chk("t4_halted", halted, 1);
    chk("t4_timeout", timeout, 1);
    chk("t4_result", result_v0, 32'hA5A5A5A5);
    do_reset();
    load_word(32'h55555555, 1);
    tick();
    repeat (MAXC - 1) tick();
    instr_address = 0; cpu_active = 0; register_v0 = 32'h0BADF00D;
    tick();
    chk("t4b_halted", halted, 1);
    chk("t4b_timeout", timeout, 0);
    chk("t4b_result", result_v0, 32'h0BADF00D);
    instr_address = BASE; cpu_active = 1;

    // 5: implicit last at DEPTH words
    do_reset();
    load_valid = 1; load_last = 0;
    for (int i = 0; i < 6; i++) begin
      load_data = 32'hD0000000 + i;
      tick();
      if (i == 3) chk("t5_ready_drop", load_ready, 0);
    end
    load_valid = 0;
    chk("t5_wc", word_count, 4);
    chk("t5_run", cpu_reset, 0);
    instr_address = BASE + 12; #1;
    chk("t5_word3", instr_readdata, 32'hD0000003);

    // 6: reset mid-run, reload one word
    tick();
    do_reset();
    chk("t6_cpu_reset", cpu_reset, 1);
    chk("t6_fault", fault, 0);
    chk("t6_wc", word_count, 0);
    load_word(32'hCAFEF00D, 1);
    instr_address = BASE; #1;
    chk("t6_word0", instr_readdata, 32'hCAFEF00D);
    instr_address = BASE + 4; #1;
    chk("t6_word1_hidden", instr_readdata, 0);

    // Randomized sessions against the model
    for (int it = 0; it < 25; it++) begin
      int n;
      bit use_last;
      do_reset();
      n = $urandom_range(1, DEPTH);
      use_last = (n < DEPTH) || ($urandom_range(0, 1) == 1);
      for (int w = 0; w < n; w++) begin
        while ($urandom_range(0, 2) == 0) begin
          load_valid = 0; load_data = $urandom; load_last = $urandom_range(0, 1);
          tick();
        end
        load_word($urandom, use_last && (w == n - 1));
      end
      for (int c = 0; c < 22; c++) begin
        instr_address = rnd_addr();
        cpu_active    = ($urandom_range(0, 3) != 0);
        register_v0   = $urandom;
        load_valid    = $urandom_range(0, 1);
        load_data     = $urandom;
        reset         = ($urandom_range(0, 40) == 0);
        tick();
        reset = 0;
      end
      load_valid = 0; cpu_active = 1; instr_address = BASE;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
